qupls_regfile_ram: RTL and testbench
====================================

QUPLS_REGFILE_RAM -- requirements
Module: qupls_regfile_ram

Interface
REQ-001 Parameter WID, default 64: data width in bits of each entry.
REQ-002 Parameter DEP, default 1024: number of entries.
REQ-003 Parameter AW, default $clog2(DEP) (10): address width.
REQ-004 clk  input  1  single clock; both ports are sampled on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 ena  input  1  port A (write port) enable.
REQ-007 wea  input  1  port A write strobe; effective only when ena=1.
REQ-008 addra  input  AW  port A write address.
REQ-009 dina  input  WID  port A write data.
REQ-010 enb  input  1  port B (read port) enable.
REQ-011 addrb  input  AW  port B read address.
REQ-012 doutb  output  WID  port B registered read data.

Function
REQ-013 Storage: DEP entries of WID bits; every entry SHALL hold zero at configuration/time zero.
REQ-014 Write: on a rising clk edge with ena=1 and wea=1, mem[addra] <= dina; with ena=0 or wea=0, no entry changes.
REQ-015 Writes to address 0 SHALL be performed like any other address; zero-register protection belongs to the parent.
REQ-016 Read: on a rising clk edge with enb=1, doutb <= mem[addrb]; latency is exactly one clock edge.
REQ-017 With enb=0, doutb SHALL hold its previous value.
REQ-018 Read-during-write, same address, same edge: read-first; doutb returns the contents before the write, and the new data is visible on the following read.
REQ-019 Read-during-write, different addresses: the two operations are independent and both complete on that edge.
REQ-020 Addresses >= DEP (when DEP is not a power of two): a write SHALL be ignored, and a read SHALL return zero.
REQ-021 No combinational path from any input to doutb.
REQ-022 The design SHALL be written so it can be inferred as a simple dual-port block RAM: one write port, one read port, output register.

Reset
REQ-023 rst_n=0 SHALL force doutb to zero immediately (asynchronously) and hold it at zero while rst_n=0.
REQ-024 Reset SHALL NOT alter memory contents; data written before reset SHALL be readable after reset.
REQ-025 A write with ena=wea=1 on an edge while rst_n=0 SHALL still update memory; reads are suppressed while rst_n=0.
REQ-026 After rst_n deasserts, the first read edge SHALL produce valid data with normal one-edge latency.

Verification
REQ-027 Basic write/read: write 0x1234 to address 5, then read address 5 with enb=1 -> doutb=0x1234 one edge after the read edge.
REQ-028 Write enables:
- ena=1, wea=0, dina=0xFFFF at address 7 -> reading address 7 returns 0.
- ena=0, wea=1 -> same result: address 7 reads 0.
REQ-029 Read-first collision: with address 3 holding 0xAA, write 0xBB to address 3 and read address 3 on the same edge -> doutb=0xAA; the next read of address 3 -> doutb=0xBB.
REQ-030 Reset: write 0x55 to address 9 and read it so doutb=0x55, then pull rst_n low mid-cycle -> doutb=0 immediately; after release, a read of address 9 -> doutb=0x55.
REQ-031 Read hold and boundary: read address 1023 holding 0xDEAD, then drop enb and change addrb -> doutb stays 0xDEAD; write then read address 0 with 0x1 -> doutb=0x1.
REQ-032 Random regression: 10,000 cycles of random ena/wea/enb/addresses against a reference model -> no mismatches.

Source files
------------

// File: rtl/qupls_regfile_ram.sv
// Simple dual-port register-file RAM: one write port (A), one registered read port (B).
// Latency: read data appears on doutb one clk edge after the read edge; writes land on the edge.
// Backpressure: none; both ports accept an operation every cycle.
module qupls_regfile_ram #(
  parameter int WID = 64,
  parameter int DEP = 1024,
  parameter int AW  = $clog2(DEP)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           wea,
  input  logic [AW-1:0]  addra,
  input  logic [WID-1:0] dina,
  input  logic           enb,
  input  logic [AW-1:0]  addrb,
  output logic [WID-1:0] doutb
);

  // Upper address bound, one bit wider than the address so DEP itself is representable.
  localparam logic [AW:0] DEP_LIM = (AW+1)'(DEP);

  // Storage starts out all-zero from configuration; reset never touches it.
  logic [WID-1:0] mem [0:DEP-1] = '{default: '0};

  logic wr_in_range;
  logic rd_in_range;

  // Addresses past the last entry only exist when DEP is not a power of two.
  assign wr_in_range = ({1'b0, addra} < DEP_LIM);
  assign rd_in_range = ({1'b0, addrb} < DEP_LIM);

  // Write port: no reset so the array maps onto block RAM; writes proceed even in reset.
  always_ff @(posedge clk) begin
    if (ena && wea && wr_in_range) begin
      mem[addra] <= dina;
    end
  end

  // Read port output register: read-first on collisions, holds when enb is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutb <= '0;
    end else if (enb) begin
      doutb <= rd_in_range ? mem[addrb] : '0;
    end
  end

endmodule

// File: tb/tb_qupls_regfile_ram.sv
module tb_qupls_regfile_ram;

  localparam int WID = 64;
  localparam int DEP = 1024;
  localparam int AW  = 10;

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic           wea;
  logic [AW-1:0]  addra;
  logic [WID-1:0] dina;
  logic           enb;
  logic [AW-1:0]  addrb;
  logic [WID-1:0] doutb;

  int tests;
  int fails;

  // Behavioural reference: a plain array of entries plus the last value read out.
  logic [WID-1:0] ref_mem [DEP];
  logic [WID-1:0] ref_dout;

  qupls_regfile_ram #(.WID(WID), .DEP(DEP), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one edge using the currently driven inputs, then step the clock.
  task automatic cycle();
    logic [WID-1:0] old;
    old = ref_mem[addrb];
    if (!rst_n) ref_dout = '0;
    else if (enb) ref_dout = old;
    if (ena && wea) ref_mem[addra] = dina;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e_a, input logic w_a, input logic [AW-1:0] a_a,
                       input logic [WID-1:0] d_a, input logic e_b, input logic [AW-1:0] a_b);
    ena = e_a; wea = w_a; addra = a_a; dina = d_a; enb = e_b; addrb = a_b;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 10'd0);
    rst_n = 1'b0;
    ref_dout = '0;
    cycle();
    cycle();
    tests++;
    if (doutb !== 64'h0) begin
      fails++;
      $display("FAIL reset_value: got %h expected %h", doutb, 64'h0);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 10'd37);
    cycle();
    tests++;
    if (doutb !== 64'h0) begin
      fails++;
      $display("FAIL time_zero_contents: got %h expected %h", doutb, 64'h0);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 10'd5, 64'h1234, 1'b0, 10'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd5);
    cycle();
    tests++;
    if (doutb !== 64'h1234) begin
      fails++;
      $display("FAIL basic_rw: got %h expected %h", doutb, 64'h1234);
    end
  endtask

  task automatic test_write_enables();
    drive(1'b1, 1'b0, 10'd7, 64'hFFFF, 1'b0, 10'd0);
    cycle();
    drive(1'b0, 1'b1, 10'd7, 64'hFFFF, 1'b0, 10'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd7);
    cycle();
    tests++;
    if (doutb !== 64'h0) begin
      fails++;
      $display("FAIL write_enable_gating: got %h expected %h", doutb, 64'h0);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b1, 10'd3, 64'hAA, 1'b0, 10'd0);
    cycle();
    drive(1'b1, 1'b1, 10'd3, 64'hBB, 1'b1, 10'd3);
    cycle();
    tests++;
    if (doutb !== 64'hAA) begin
      fails++;
      $display("FAIL read_first_old: got %h expected %h", doutb, 64'hAA);
    end
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd3);
    cycle();
    tests++;
    if (doutb !== 64'hBB) begin
      fails++;
      $display("FAIL read_first_new: got %h expected %h", doutb, 64'hBB);
    end
    // Different addresses on the same edge are independent.
    drive(1'b1, 1'b1, 10'd4, 64'hCC, 1'b1, 10'd5);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd4);
    tests++;
    if (doutb !== 64'h1234) begin
      fails++;
      $display("FAIL diff_addr_read: got %h expected %h", doutb, 64'h1234);
    end
    cycle();
    tests++;
    if (doutb !== 64'hCC) begin
      fails++;
      $display("FAIL diff_addr_write: got %h expected %h", doutb, 64'hCC);
    end
  endtask

  task automatic test_reset_preserve();
    drive(1'b1, 1'b1, 10'd9, 64'h55, 1'b0, 10'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd9);
    cycle();
    tests++;
    if (doutb !== 64'h55) begin
      fails++;
      $display("FAIL pre_reset_read: got %h expected %h", doutb, 64'h55);
    end
    // Assert reset mid-cycle, well away from any clock edge.
    #3;
    rst_n = 1'b0;
    ref_dout = '0;
    #1;
    tests++;
    if (doutb !== 64'h0) begin
      fails++;
      $display("FAIL async_reset_clear: got %h expected %h", doutb, 64'h0);
    end
    // Write during reset still lands; the read is suppressed.
    drive(1'b1, 1'b1, 10'd11, 64'h77, 1'b1, 10'd9);
    cycle();
    tests++;
    if (doutb !== 64'h0) begin
      fails++;
      $display("FAIL reset_hold: got %h expected %h", doutb, 64'h0);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd9);
    cycle();
    tests++;
    if (doutb !== 64'h55) begin
      fails++;
      $display("FAIL post_reset_read: got %h expected %h", doutb, 64'h55);
    end
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd11);
    cycle();
    tests++;
    if (doutb !== 64'h77) begin
      fails++;
      $display("FAIL write_in_reset: got %h expected %h", doutb, 64'h77);
    end
  endtask

  task automatic test_hold_boundary();
    drive(1'b1, 1'b1, 10'd1023, 64'hDEAD, 1'b0, 10'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd1023);
    cycle();
    tests++;
    if (doutb !== 64'hDEAD) begin
      fails++;
      $display("FAIL top_addr_read: got %h expected %h", doutb, 64'hDEAD);
    end
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b0, 10'd17);
    cycle();
    cycle();
    tests++;
    if (doutb !== 64'hDEAD) begin
      fails++;
      $display("FAIL read_hold: got %h expected %h", doutb, 64'hDEAD);
    end
    drive(1'b1, 1'b1, 10'd0, 64'h1, 1'b0, 10'd0);
    cycle();
    drive(1'b0, 1'b0, 10'd0, 64'h0, 1'b1, 10'd0);
    cycle();
    tests++;
    if (doutb !== 64'h1) begin
      fails++;
      $display("FAIL addr_zero_write: got %h expected %h", doutb, 64'h1);
    end
  endtask

  task automatic test_random();
    int nfail;
    nfail = 0;
    for (int i = 0; i < 10000; i++) begin
      ena   = 1'($urandom_range(0, 1));
      wea   = 1'($urandom_range(0, 3) != 0);
      enb   = 1'($urandom_range(0, 3) != 0);
      // Half the time use a small window of addresses to provoke collisions.
      addra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      addrb = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      dina  = {$urandom, $urandom};
      cycle();
      tests++;
      if (doutb !== ref_dout) begin
        fails++;
        nfail++;
        if (nfail <= 10)
          $display("FAIL random_cycle_%0d: got %h expected %h", i, doutb, ref_dout);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    ref_dout = '0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    test_reset();
    test_basic();
    test_write_enables();
    test_collision();
    test_reset_preserve();
    test_hold_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
